bank_req_queue: RTL and testbench

Per-bank ingress queue between the crossbar's bank-side request output and the cache bank pipeline. It accepts one `bank_req_t` per cycle, buffers requests in strict arrival order, and presents the oldest request to the bank with a valid/ready handshake. It also reports its occupancy and which of the three channels have requests queued, so upstream logic can throttle. One instance sits in front of each of banks 0–3.

---
 rtl/mpc_types.sv | 39 +++
 rtl/bank_req_queue.sv | 109 ++++++++++
 tb/tb_bank_req_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mpc_types.sv
// Shared memory-path types: request structs, channel count and default queue depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mpc_types;

  localparam int NUM_CH       = 3;
  localparam int BANK_Q_DEPTH = 4;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;

  typedef enum logic [1:0] {
    OP_RD    = 2'd0,
    OP_WR    = 2'd1,
    OP_AMO   = 2'd2,
    OP_FLUSH = 2'd3
  } mem_op_e;

  // Global configuration; sim_chk_off silences the simulation-only checks.
  typedef struct packed {
    logic       sim_chk_off;
    logic [6:0] rsvd;
  } mpc_cfg_t;

  // Request as issued by one channel, before the crossbar tags it.
  typedef struct packed {
    mem_op_e           op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } channel_req_t;

  // Request as delivered to a bank, tagged with its source channel.
  typedef struct packed {
    logic [NUM_CH-1:0] channel_1hot_id;
    mem_op_e           op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bank_req_t;

endpackage

// File: rtl/bank_req_queue.sv
// Per-bank ingress FIFO with occupancy and per-channel pending flags.
// Latency: push in cycle N is visible at the head in cycle N+1 (no bypass).
// Backpressure: u_req_ready = !full, purely from state; head held while d_req_ready is low.
module bank_req_queue
  import mpc_types::*;
#(
  parameter mpc_cfg_t Cfg   = '0,
  parameter int       DEPTH = BANK_Q_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       u_req_valid,
  output logic                       u_req_ready,
  input  bank_req_t                  u_req,
  output logic                       d_req_valid,
  input  logic                       d_req_ready,
  output bank_req_t                  d_req,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [NUM_CH-1:0]          ch_pending
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  bank_req_t               mem [DEPTH];
  logic [PW-1:0]           w_ptr;
  logic [PW-1:0]           r_ptr;
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic [NUM_CH-1:0][PW-1:0] ch_cnt;

  // MSB of each pointer is the wrap bit; equal indices with differing wrap means full.
  assign empty = (w_ptr == r_ptr);
  assign full  = (w_ptr[IW-1:0] == r_ptr[IW-1:0]) && (w_ptr[IW] != r_ptr[IW]);

  assign u_req_ready = !full;
  assign d_req_valid = !empty;
  assign push        = u_req_valid & u_req_ready;
  assign pop         = d_req_valid & d_req_ready;

  assign d_req     = mem[r_ptr[IW-1:0]];
  assign occupancy = w_ptr - r_ptr;

  // Pointers advance modulo 2*DEPTH; reset discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (push) w_ptr <= w_ptr + 1'b1;
      if (pop)  r_ptr <= r_ptr + 1'b1;
    end
  end

  // Payload storage is not reset; d_req is meaningless while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[w_ptr[IW-1:0]] <= u_req;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          inc;
    logic          dec;
    logic [PW-1:0] cnt;

    assign inc = push & u_req.channel_1hot_id[i];
    assign dec = pop & d_req.channel_1hot_id[i];

    // Count queued entries from channel i; a matching push and pop cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt <= cnt + 1'b1;
      end else if (dec && !inc) begin
        cnt <= cnt - 1'b1;
      end
    end

    assign ch_cnt[i]     = cnt;
    assign ch_pending[i] = (cnt != '0);
  end

  logic [PW+1:0] ch_sum;

  // Total of the per-channel counters, used only by the consistency checks below.
  always_comb begin
    ch_sum = '0;
    for (int i = 0; i < NUM_CH; i++) ch_sum = ch_sum + {2'b00, ch_cnt[i]};
  end

  // Simulation checks: one-hot channel tag on push, counter bound, counter total matches occupancy.
  always @(posedge clk) begin
    if (rst_n && !Cfg.sim_chk_off) begin
      if (push) begin
        assert ($onehot(u_req.channel_1hot_id))
          else $error("bank_req_queue: pushed channel_1hot_id %b not one-hot", u_req.channel_1hot_id);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        assert (ch_cnt[i] <= PW'(DEPTH))
          else $error("bank_req_queue: ch_cnt[%0d]=%0d exceeds depth", i, ch_cnt[i]);
      end
      assert (ch_sum == {2'b00, occupancy})
        else $error("bank_req_queue: channel count total %0d != occupancy %0d", ch_sum, occupancy);
    end
  end

endmodule

// File: tb/tb_bank_req_queue.sv
// Randomized and directed bench for bank_req_queue against a queue-based reference.
// Latency: reference mirrors the one-cycle push-to-head delay of the queue.
// Backpressure: reference accepts only while fewer than DEPTH entries are held.
module tb_bank_req_queue;
  import mpc_types::*;

  localparam int DEPTH = BANK_Q_DEPTH;

  logic                   clk;
  logic                   rst_n;
  logic                   u_req_valid;
  logic                   u_req_ready;
  bank_req_t              u_req;
  logic                   d_req_valid;
  logic                   d_req_ready;
  bank_req_t              d_req;
  logic [$clog2(DEPTH):0] occupancy;
  logic [NUM_CH-1:0]      ch_pending;

  int checks;
  int failures;

  bank_req_t model_q[$];

  bank_req_queue #(.Cfg('0), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .u_req_valid(u_req_valid),
    .u_req_ready(u_req_ready),
    .u_req      (u_req),
    .d_req_valid(d_req_valid),
    .d_req_ready(d_req_ready),
    .d_req      (d_req),
    .occupancy  (occupancy),
    .ch_pending (ch_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bank_req_t mk_req(input int ch, input logic [31:0] addr);
    bank_req_t r;
    r.channel_1hot_id = 3'(1 << ch);
    r.op              = mem_op_e'($urandom_range(0, 3));
    r.addr            = addr;
    r.wdata           = $urandom;
    return r;
  endfunction

  // Compare every visible output against the reference queue contents.
  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0] exp_pend;
    exp_pend = '0;
    foreach (model_q[i]) exp_pend |= model_q[i].channel_1hot_id;
    chk({tag, ".d_vld"}, 128'(d_req_valid), 128'(model_q.size() != 0));
    chk({tag, ".u_rdy"}, 128'(u_req_ready), 128'(model_q.size() < DEPTH));
    chk({tag, ".occ"},   128'(occupancy),   128'(model_q.size()));
    chk({tag, ".pend"},  128'(ch_pending),  128'(exp_pend));
    if (model_q.size() != 0) chk({tag, ".d_req"}, 128'(d_req), 128'(model_q[0]));
  endtask

  // Called at a negedge: check state, drive this cycle's inputs, advance the reference.
  task automatic cycle(input string tag, input logic v, input bank_req_t r, input logic rdy);
    bit do_push;
    bit do_pop;
    check_outputs(tag);
    u_req_valid = v;
    u_req       = r;
    d_req_ready = rdy;
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = rdy && (model_q.size() > 0);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(r);
    @(negedge clk);
  endtask

  initial begin
    bank_req_t r;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    u_req_valid = 1'b0;
    d_req_ready = 1'b0;
    u_req       = '0;

    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single pass: push ch1 into empty queue, pop it the next cycle.
    cycle("single_push", 1'b1, mk_req(1, 32'h40), 1'b0);
    chk("single.head_addr", 128'(d_req.addr), 128'(32'h40));
    cycle("single_pop", 1'b0, '0, 1'b1);
    cycle("single_idle", 1'b0, '0, 1'b0);

    // Fill to full, hold a 5th request, then release one slot.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, mk_req(i % 3, 32'(i * 'h40)), 1'b0);
    r = mk_req(0, 32'h100);
    cycle("full_hold", 1'b1, r, 1'b0);
    chk("full.u_rdy_low", 128'(u_req_ready), 128'(0));
    cycle("full_pop", 1'b1, r, 1'b1);
    cycle("full_accept", 1'b1, r, 1'b0);
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, '0, 1'b1);
    cycle("drain_done", 1'b0, '0, 1'b0);

    // Simultaneous push/pop at occupancy 2 with a ch2 head.
    cycle("sim_a", 1'b1, mk_req(2, 32'h200), 1'b0);
    cycle("sim_b", 1'b1, mk_req(1, 32'h240), 1'b0);
    cycle("sim_pp", 1'b1, mk_req(0, 32'h280), 1'b1);
    chk("sim.occ_held", 128'(occupancy), 128'(2));

    // Backpressure hold over five cycles.
    for (int i = 0; i < 5; i++) cycle("bp_hold", 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("bp_drain", 1'b0, '0, 1'b1);

    // Streaming wrap-around with the sink always ready.
    for (int i = 0; i < 10; i++) begin
      cycle("wrap", 1'b1, mk_req(i % 3, 32'(i * 'h10)), 1'b1);
      chk("wrap.occ_le1", 128'(occupancy <= 1), 128'(1));
    end
    cycle("wrap_end", 1'b0, '0, 1'b1);

    // Randomized traffic with varying push/pop pressure.
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 100; i++) begin
        logic v;
        logic rdy;
        v   = ($urandom_range(0, 3) < (seg + 1));
        rdy = ($urandom_range(0, 3) < (4 - seg));
        cycle("rand", v, mk_req($urandom_range(0, 2), $urandom), rdy);
      end
    end

    // Reset mid-stream with three entries queued.
    cycle("pre_rst_drain", 1'b0, '0, 1'b1);
    cycle("pre_rst_drain", 1'b0, '0, 1'b1);
    cycle("pre_rst_drain", 1'b0, '0, 1'b1);
    cycle("pre_rst_drain", 1'b0, '0, 1'b1);
    cycle("pre_rst_drain", 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, mk_req(i, 32'(i * 4)), 1'b0);
    check_outputs("pre_rst_state");
    u_req_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    model_q.delete();
    chk("rst.d_vld", 128'(d_req_valid), 128'(0));
    chk("rst.occ",   128'(occupancy),   128'(0));
    chk("rst.pend",  128'(ch_pending),  128'(0));
    chk("rst.u_rdy", 128'(u_req_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle("post_rst", 1'b1, mk_req(2, 32'h500), 1'b0);
    cycle("post_rst_pop", 1'b0, '0, 1'b1);
    check_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
